bus_mem_responder: RTL and testbench

Bus-side responder (slave) for the system's shared 32-bit request/ack bus. It is the target end of transactions issued by bus initiators such as the UART bridge. It decodes the address phase and inserts a programmable number of wait states through the wait bit of the control field. It then accepts write data into, or returns read data from, a small local word-addressed memory, with optional incrementing bursts.

---
 rtl/bus_mem_responder.sv | 74 +++++++
 tb/tb_bus_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: bus target with programmable wait states and a small word memory.
// Define BUS_RESP_BURST_EN for incrementing, wrapping bursts of 1..8 beats.
module bus_mem_responder #(
  parameter int          BUS_WIDTH   = 32,
  parameter int          CTRL_WIDTH  = 8,
  parameter int          ADDR_BITS   = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                  clk50MHz,
  input  logic                  reset_n,
  input  logic                  bus_addr_valid,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
  state_t r_state, w_next;
  logic [BUS_WIDTH-1:0] r_mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] r_ptr;
  logic [3:0] r_cnt;
  logic r_we, r_err;
  logic w_hit, w_last, w_unused;
  assign w_hit = bus_addr_valid && (bus_in[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign w_unused = ^ctrl_in;
  assign err = r_err;
`ifdef BUS_RESP_BURST_EN
  logic [2:0] r_len;
  always_ff @(posedge clk50MHz or negedge reset_n) begin
    if (!reset_n) r_len <= '0;
    else if (r_state == IDLE && w_hit) r_len <= ctrl_in[4:2];
    else if (r_state == DATA && r_len != 3'd0) r_len <= r_len - 3'd1;
  end
  assign w_last = (r_len == 3'd0);
`else
  assign w_last = 1'b1;
`endif
  always_ff @(posedge clk50MHz or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    ctrl_out = '0;
    bus_out = '0;
    w_next = (r_state == IDLE && w_hit) ? WAIT :
             (r_state == WAIT && r_cnt == 4'd0) ? DATA :
             (r_state == DATA && w_last) ? IDLE : r_state;
    ctrl_out[0] = (r_state == WAIT) && (r_cnt != 4'd0);
    bus_out = (r_state == DATA && !r_we) ? r_mem[r_ptr] : '0;
  end
  always_ff @(posedge clk50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_we <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= bus_addr_valid && (r_state != IDLE);
      if (r_state == IDLE && w_hit) begin
        r_ptr <= bus_in[ADDR_BITS+1:2];
        r_we <= ctrl_in[1];
        r_cnt <= 4'(WAIT_CYCLES);
      end else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      else if (r_state == DATA) r_ptr <= r_ptr + 1'b1;
    end
  end
  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk50MHz) begin
    if (r_state == DATA && r_we) r_mem[r_ptr] <= bus_in;
  end
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: transaction-level model plus directed vectors for bus_mem_responder.
module tb_bus_mem_responder;
  localparam int WC = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef BUS_RESP_BURST_EN
  localparam int L4 = 4;
`else
  localparam int L4 = 1;
`endif
  logic clk = 1'b0;
  logic reset_n;
  logic bus_addr_valid;
  logic [31:0] bus_in;
  logic [7:0] ctrl_in;
  logic [31:0] bus_out;
  logic [7:0] ctrl_out;
  logic err;
  int n_tests = 0;
  int n_fail = 0;

  bus_mem_responder #(.WAIT_CYCLES(WC)) dut (
    .clk50MHz(clk), .reset_n(reset_n), .bus_addr_valid(bus_addr_valid),
    .bus_in(bus_in), .ctrl_in(ctrl_in), .bus_out(bus_out), .ctrl_out(ctrl_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: one active transaction, timed relative to its address edge.
  int cyc = 0;
  int t0 = 0;
  bit act = 0;
  bit m_we = 0;
  int m_ptr = 0;
  int m_len = 1;
  logic [31:0] m_mem [16];
  logic e_err = 1'b0;

  always @(posedge clk) begin
    int k;
    if (!reset_n) begin
      act = 0;
      e_err = 1'b0;
    end else begin
      k = cyc - t0;
      e_err = bus_addr_valid && act;
      if (act && k >= WC + 2) begin
        if (m_we) m_mem[(m_ptr + k - WC - 2) % 16] = bus_in;
        if (k == WC + 1 + m_len) act = 0;
      end else if (!act && bus_addr_valid && bus_in >= BASE && bus_in < BASE + 64) begin
        act = 1;
        t0 = cyc;
        m_we = ctrl_in[1];
        m_ptr = int'((bus_in - BASE) / 4);
`ifdef BUS_RESP_BURST_EN
        m_len = int'(ctrl_in[4:2]) + 1;
`else
        m_len = 1;
`endif
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    int k, b;
    logic ew;
    logic [31:0] eb;
    if (!reset_n) begin
      chk("rst_bus_out", bus_out, 32'h0);
      chk("rst_ctrl_out", {24'h0, ctrl_out}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
    end else begin
      k = cyc - t0;
      b = k - WC - 2;
      ew = act && k >= 1 && k <= WC;
      eb = (act && !m_we && b >= 0 && b < m_len) ? m_mem[(m_ptr + b) % 16] : 32'h0;
      chk("ctrl_out", {24'h0, ctrl_out}, {31'h0, ew});
      chk("bus_out", bus_out, eb);
      chk("err", {31'h0, err}, {31'h0, e_err});
    end
  end

  logic [31:0] wdata [8];
  logic [31:0] rdat [8];
  logic wt [16];
  logic er [16];

  task automatic txn(input logic [31:0] addr, input logic [7:0] ctrl, input bit bump, input int beats);
    @(negedge clk);
    bus_addr_valid = 1'b1;
    bus_in = addr;
    ctrl_in = ctrl;
    @(negedge clk);
    bus_addr_valid = bump;
    bus_in = bump ? 32'h0000_1004 : 32'h0;
    ctrl_in = 8'h0;
    wt[1] = ctrl_out[0];
    er[1] = err;
    for (int j = 0; j <= WC; j++) begin
      @(negedge clk);
      bus_addr_valid = 1'b0;
      bus_in = 32'h0;
      if (j < WC) wt[j + 2] = ctrl_out[0];
      er[j + 2] = err;
    end
    for (int i = 0; i < beats; i++) begin
      bus_in = wdata[i];
      rdat[i] = bus_out;
      @(negedge clk);
    end
    bus_in = 32'h0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus_addr_valid = 1'b0;
    bus_in = 32'h0;
    ctrl_in = 8'h0;
    @(negedge clk);
    chk("reset_bus_out", bus_out, 32'h0);
    chk("reset_ctrl_out", {24'h0, ctrl_out}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    wdata[0] = 32'hDEAD_BEEF;
    txn(32'h0000_1008, 8'h02, 0, 1);
    chk("wr_wait_T1", {31'h0, wt[1]}, 32'h1);
    chk("wr_wait_T2", {31'h0, wt[2]}, 32'h1);
    chk("wr_wait_T3", {31'h0, wt[3]}, 32'h0);
    txn(32'h0000_1008, 8'h00, 0, 1);
    chk("rd_single", rdat[0], 32'hDEAD_BEEF);
    chk("rd_after_idle", bus_out, 32'h0);

    wdata[0] = 32'h1111_2222;
    txn(32'h0000_2008, 8'h02, 0, 1);
    chk("miss_wait", {31'h0, wt[1]}, 32'h0);
    txn(32'h0000_1008, 8'h00, 0, 1);
    chk("miss_no_write", rdat[0], 32'hDEAD_BEEF);

    for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
    txn(32'h0000_1038, 8'h0E, 0, L4);
    txn(32'h0000_1038, 8'h0C, 0, L4);
    for (int i = 0; i < L4; i++) chk("burst_rd", rdat[i], 32'(i + 1));
`ifdef BUS_RESP_BURST_EN
    txn(32'h0000_1000, 8'h00, 0, 1);
    chk("wrap_mem0", rdat[0], 32'h3);
`endif

    wdata[0] = 32'hCAFE_0001;
    txn(32'h0000_1010, 8'h02, 1, 1);
    chk("ovl_err_T1", {31'h0, er[1]}, 32'h0);
    chk("ovl_err_T2", {31'h0, er[2]}, 32'h1);
    chk("ovl_err_T3", {31'h0, er[3]}, 32'h0);
    txn(32'h0000_1010, 8'h00, 0, 1);
    chk("ovl_data", rdat[0], 32'hCAFE_0001);

    @(negedge clk);
    bus_addr_valid = 1'b1;
    bus_in = 32'h0000_1038;
    ctrl_in = 8'h0C;
    @(negedge clk);
    bus_addr_valid = 1'b0;
    bus_in = 32'h0;
    ctrl_in = 8'h0;
    repeat (WC + 1) @(negedge clk);
    if (L4 > 1) begin
      @(negedge clk);
      chk("mid_burst_data", bus_out, 32'h2);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_bus_out", bus_out, 32'h0);
    chk("async_rst_ctrl_out", {24'h0, ctrl_out}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    txn(32'h0000_1008, 8'h00, 0, 1);
    chk("post_rst_read", rdat[0], 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
